vga_timing_gen: RTL and testbench

Parametrised, multi-mode VGA timing generator producing pixel/line counters, blanking and polarity-correct sync strobes for the display pipeline. It holds two compile-time timing modes and switches between them at runtime, only at frame boundaries. A pixel-enable input allows running at a multiple of the pixel clock. It sits at the head of the video chain, driving the draw/overlay stages and the frame-rate logic via `new_frame`.

---
 rtl/vga_pkg.sv | 40 ++++
 rtl/vga_timing_axis.sv | 62 ++++++
 rtl/vga_timing_gen.sv | 104 ++++++++++
 tb/tb_vga_timing_gen.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing descriptors and helpers for the timing generator.
package vga_pkg;

  localparam int unsigned TIM_W = 11;

  typedef struct packed {
    logic [TIM_W-1:0] h_active;
    logic [TIM_W-1:0] h_fp;
    logic [TIM_W-1:0] h_sync;
    logic [TIM_W-1:0] h_bp;
    logic [TIM_W-1:0] v_active;
    logic [TIM_W-1:0] v_fp;
    logic [TIM_W-1:0] v_sync;
    logic [TIM_W-1:0] v_bp;
    logic             hs_pol;
    logic             vs_pol;
  } timing_t;

  localparam timing_t MODE_1024x768_60 = '{
    h_active: 11'd1024, h_fp: 11'd24, h_sync: 11'd136, h_bp: 11'd160,
    v_active: 11'd768,  v_fp: 11'd3,  v_sync: 11'd6,   v_bp: 11'd29,
    hs_pol: 1'b0, vs_pol: 1'b0
  };

  localparam timing_t MODE_800x600_60 = '{
    h_active: 11'd800, h_fp: 11'd40, h_sync: 11'd128, h_bp: 11'd88,
    v_active: 11'd600, v_fp: 11'd1,  v_sync: 11'd4,   v_bp: 11'd23,
    hs_pol: 1'b1, vs_pol: 1'b1
  };

  // Full-precision totals, used to range-check descriptors at elaboration.
  function automatic int unsigned h_total(timing_t t);
    return 32'(t.h_active) + 32'(t.h_fp) + 32'(t.h_sync) + 32'(t.h_bp);
  endfunction

  function automatic int unsigned v_total(timing_t t);
    return 32'(t.v_active) + 32'(t.v_fp) + 32'(t.v_sync) + 32'(t.v_bp);
  endfunction

endpackage

// File: rtl/vga_timing_axis.sv
// One timing axis: wrapping counter with registered blank/sync flags.
module vga_timing_axis
  import vga_pkg::*;
#(
  parameter int unsigned CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic [CNT_W-1:0] cur_active,
  input  logic [CNT_W-1:0] cur_fp,
  input  logic [CNT_W-1:0] cur_sync,
  input  logic [CNT_W-1:0] cur_bp,
  input  logic [CNT_W-1:0] nxt_active,
  input  logic [CNT_W-1:0] nxt_fp,
  input  logic [CNT_W-1:0] nxt_sync,
  input  logic             nxt_pol,
  output logic [CNT_W-1:0] count,
  output logic             blank,
  output logic             sync,
  output logic             wrap
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] last_c, sync_lo_c;
  logic             blank_q, blank_d;
  logic             sync_q, sync_d;

  // Wrap uses the mode in force now; flags for the new count use the incoming mode.
  assign last_c    = cur_active + cur_fp + cur_sync + cur_bp - CNT_W'(1);
  assign wrap      = step && (count_q == last_c);
  assign sync_lo_c = nxt_active + nxt_fp;

  always_comb begin
    count_d = count_q;
    blank_d = blank_q;
    sync_d  = sync_q;
    if (step) begin
      count_d = wrap ? '0 : count_q + CNT_W'(1);
      blank_d = (count_d >= nxt_active);
      // Modular offset test avoids overflow of the sync end bound.
      sync_d  = ((count_d - sync_lo_c) < nxt_sync) ~^ nxt_pol;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      blank_q <= 1'b0;
      sync_q  <= ~nxt_pol;
    end else begin
      count_q <= count_d;
      blank_q <= blank_d;
      sync_q  <= sync_d;
    end
  end

  assign count = count_q;
  assign blank = blank_q;
  assign sync  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Two-mode VGA timing generator with frame-boundary mode switching and pixel strobe.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CNT_W = 11,
  parameter timing_t     MODE0 = MODE_1024x768_60,
  parameter timing_t     MODE1 = MODE_800x600_60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode_sel,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hblnk,
  output logic             vblnk,
  output logic             hsync,
  output logic             vsync,
  output logic             new_line,
  output logic             new_frame,
  output logic             mode_active
);

  localparam int unsigned MAX_TOTAL = 32'(1) << CNT_W;

  if (h_total(MODE0) > MAX_TOTAL || v_total(MODE0) > MAX_TOTAL) begin : g_mode0_range
    $error("vga_timing_gen: MODE0 totals exceed counter range");
  end
  if (h_total(MODE1) > MAX_TOTAL || v_total(MODE1) > MAX_TOTAL) begin : g_mode1_range
    $error("vga_timing_gen: MODE1 totals exceed counter range");
  end

  logic    mode_q, mode_d, nxt_sel_c;
  logic    new_line_q, new_line_d;
  logic    new_frame_q, new_frame_d;
  logic    h_wrap, v_wrap;
  timing_t cur_t, nxt_t;

  // Reset adopts mode_sel immediately so the reset sync level matches that mode.
  assign nxt_sel_c = rst ? mode_sel : mode_d;
  assign cur_t     = mode_q ? MODE1 : MODE0;
  assign nxt_t     = nxt_sel_c ? MODE1 : MODE0;

  always_comb begin
    mode_d      = mode_q;
    new_line_d  = h_wrap;
    new_frame_d = v_wrap;
    if (v_wrap) mode_d = mode_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= mode_sel;
      new_line_q  <= 1'b0;
      new_frame_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      new_line_q  <= new_line_d;
      new_frame_q <= new_frame_d;
    end
  end

  vga_timing_axis #(.CNT_W(CNT_W)) u_h_axis (
    .clk        (clk),
    .rst        (rst),
    .step       (en),
    .cur_active (CNT_W'(cur_t.h_active)),
    .cur_fp     (CNT_W'(cur_t.h_fp)),
    .cur_sync   (CNT_W'(cur_t.h_sync)),
    .cur_bp     (CNT_W'(cur_t.h_bp)),
    .nxt_active (CNT_W'(nxt_t.h_active)),
    .nxt_fp     (CNT_W'(nxt_t.h_fp)),
    .nxt_sync   (CNT_W'(nxt_t.h_sync)),
    .nxt_pol    (nxt_t.hs_pol),
    .count      (hcount),
    .blank      (hblnk),
    .sync       (hsync),
    .wrap       (h_wrap)
  );

  // Vertical axis advances once per completed line; its wrap marks the frame boundary.
  vga_timing_axis #(.CNT_W(CNT_W)) u_v_axis (
    .clk        (clk),
    .rst        (rst),
    .step       (h_wrap),
    .cur_active (CNT_W'(cur_t.v_active)),
    .cur_fp     (CNT_W'(cur_t.v_fp)),
    .cur_sync   (CNT_W'(cur_t.v_sync)),
    .cur_bp     (CNT_W'(cur_t.v_bp)),
    .nxt_active (CNT_W'(nxt_t.v_active)),
    .nxt_fp     (CNT_W'(nxt_t.v_fp)),
    .nxt_sync   (CNT_W'(nxt_t.v_sync)),
    .nxt_pol    (nxt_t.vs_pol),
    .count      (vcount),
    .blank      (vblnk),
    .sync       (vsync),
    .wrap       (v_wrap)
  );

  assign new_line    = new_line_q;
  assign new_frame   = new_frame_q;
  assign mode_active = mode_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a reference model pushes expected outputs per clock, popped after each edge.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam timing_t SM0 = '{
    h_active: 11'd16, h_fp: 11'd2, h_sync: 11'd3, h_bp: 11'd4,
    v_active: 11'd10, v_fp: 11'd1, v_sync: 11'd2, v_bp: 11'd3,
    hs_pol: 1'b0, vs_pol: 1'b0
  };
  localparam timing_t SM1 = '{
    h_active: 11'd12, h_fp: 11'd0, h_sync: 11'd2, h_bp: 11'd0,
    v_active: 11'd8,  v_fp: 11'd2, v_sync: 11'd1, v_bp: 11'd0,
    hs_pol: 1'b1, vs_pol: 1'b1
  };

  typedef struct { int h; int v; bit mode; bit nl; bit nf; } mst_t;

  logic clk;
  logic s_rst, s_en, s_sel, b_rst, b_en, b_sel;
  logic [10:0] s_hc, s_vc, b_hc, b_vc;
  logic s_hb, s_vb, s_hs, s_vs, s_nl, s_nf, s_ma;
  logic b_hb, b_vb, b_hs, b_vs, b_nl, b_nf, b_ma;
  logic [28:0] s_vec, b_vec, exp_s, exp_b;
  logic [28:0] sq_s[$], sq_b[$];
  mst_t ms, mb;
  int n_cmp, n_fail;

  assign s_vec = {s_hc, s_vc, s_hb, s_vb, s_hs, s_vs, s_nl, s_nf, s_ma};
  assign b_vec = {b_hc, b_vc, b_hb, b_vb, b_hs, b_vs, b_nl, b_nf, b_ma};

  vga_timing_gen #(.CNT_W(11), .MODE0(SM0), .MODE1(SM1)) u_small (
    .clk(clk), .rst(s_rst), .en(s_en), .mode_sel(s_sel),
    .hcount(s_hc), .vcount(s_vc), .hblnk(s_hb), .vblnk(s_vb),
    .hsync(s_hs), .vsync(s_vs), .new_line(s_nl), .new_frame(s_nf), .mode_active(s_ma)
  );

  vga_timing_gen u_big (
    .clk(clk), .rst(b_rst), .en(b_en), .mode_sel(b_sel),
    .hcount(b_hc), .vcount(b_vc), .hblnk(b_hb), .vblnk(b_vb),
    .hsync(b_hs), .vsync(b_vs), .new_line(b_nl), .new_frame(b_nf), .mode_active(b_ma)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int tot_h(timing_t t);
    return int'(t.h_active) + int'(t.h_fp) + int'(t.h_sync) + int'(t.h_bp);
  endfunction
  function automatic int tot_v(timing_t t);
    return int'(t.v_active) + int'(t.v_fp) + int'(t.v_sync) + int'(t.v_bp);
  endfunction

  function automatic mst_t m_step(mst_t s, bit r, bit e, bit sel, timing_t m0, timing_t m1);
    mst_t n;
    timing_t t;
    n = s;
    t = s.mode ? m1 : m0;
    n.nl = 1'b0;
    n.nf = 1'b0;
    if (r) begin
      n.h = 0; n.v = 0; n.mode = sel;
    end else if (e) begin
      if (s.h == tot_h(t) - 1) begin
        n.h = 0; n.nl = 1'b1;
        if (s.v == tot_v(t) - 1) begin
          n.v = 0; n.nf = 1'b1; n.mode = sel;
        end else n.v = s.v + 1;
      end else n.h = s.h + 1;
    end
    return n;
  endfunction

  function automatic logic [28:0] m_vec(mst_t s, timing_t m0, timing_t m1);
    timing_t t;
    int hso, hse, vso, vse;
    bit hin, vin, hb, vb, hs, vs;
    t = s.mode ? m1 : m0;
    hso = int'(t.h_active) + int'(t.h_fp);
    hse = hso + int'(t.h_sync);
    vso = int'(t.v_active) + int'(t.v_fp);
    vse = vso + int'(t.v_sync);
    hin = (s.h >= hso) && (s.h < hse);
    vin = (s.v >= vso) && (s.v < vse);
    hb  = s.h >= int'(t.h_active);
    vb  = s.v >= int'(t.v_active);
    hs  = t.hs_pol ? hin : !hin;
    vs  = t.vs_pol ? vin : !vin;
    return {11'(s.h), 11'(s.v), hb, vb, hs, vs, s.nl, s.nf, s.mode};
  endfunction

  task automatic tick_s(input bit r, input bit e, input bit sel);
    s_rst = r; s_en = e; s_sel = sel;
    ms = m_step(ms, r, e, sel, SM0, SM1);
    sq_s.push_back(m_vec(ms, SM0, SM1));
    @(posedge clk); #1;
    exp_s = sq_s.pop_front();
  endtask

  task automatic tick_b(input bit r, input bit e, input bit sel);
    b_rst = r; b_en = e; b_sel = sel;
    mb = m_step(mb, r, e, sel, MODE_1024x768_60, MODE_800x600_60);
    sq_b.push_back(m_vec(mb, MODE_1024x768_60, MODE_800x600_60));
    @(posedge clk); #1;
    exp_b = sq_b.pop_front();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      tick_b(1'b1, 1'b1, 1'b0);
      n_cmp++; if (b_vec !== exp_b) begin n_fail++; $display("FAIL sb_reset_big: got %h want %h", b_vec, exp_b); end
    end
    n_cmp++; if ({b_hc, b_vc} !== 22'd0) begin n_fail++; $display("FAIL reset_counts: got %h want 0", {b_hc, b_vc}); end
    n_cmp++; if ({b_hs, b_vs} !== 2'b11) begin n_fail++; $display("FAIL reset_sync: got %b want 11", {b_hs, b_vs}); end
    n_cmp++; if ({b_ma, b_nl, b_nf, b_hb, b_vb} !== 5'd0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {b_ma, b_nl, b_nf, b_hb, b_vb}); end
    tick_s(1'b1, 1'b0, 1'b1);
    n_cmp++; if (s_vec !== exp_s) begin n_fail++; $display("FAIL sb_reset_sel1: got %h want %h", s_vec, exp_s); end
    n_cmp++; if ({s_ma, s_hs, s_vs} !== 3'b100) begin n_fail++; $display("FAIL reset_mode1_sync: got %b want 100", {s_ma, s_hs, s_vs}); end
    for (int i = 0; i < 2; i++) begin
      tick_s(1'b1, 1'b1, 1'b0);
      n_cmp++; if (s_vec !== exp_s) begin n_fail++; $display("FAIL sb_reset_sel0: got %h want %h", s_vec, exp_s); end
    end
  endtask

  task automatic test_mode0_line();
    int rise_hc, lo_min, lo_max, lo_cnt, nl_cnt;
    logic prev_hb;
    rise_hc = -1; lo_min = 99999; lo_max = -1; lo_cnt = 0; nl_cnt = 0; prev_hb = 1'b0;
    for (int i = 0; i < 2 * 1344; i++) begin
      tick_b(1'b0, 1'b1, 1'b0);
      n_cmp++; if (b_vec !== exp_b) begin n_fail++; $display("FAIL sb_line: cyc %0d got %h want %h", i, b_vec, exp_b); end
      if (b_hb && !prev_hb && rise_hc < 0) rise_hc = int'(b_hc);
      prev_hb = b_hb;
      if (!b_hs) begin
        lo_cnt++;
        if (int'(b_hc) < lo_min) lo_min = int'(b_hc);
        if (int'(b_hc) > lo_max) lo_max = int'(b_hc);
      end
      if (b_nl) nl_cnt++;
    end
    n_cmp++; if (rise_hc != 1024) begin n_fail++; $display("FAIL hblnk_rise: got %0d want 1024", rise_hc); end
    n_cmp++; if (lo_min != 1048 || lo_max != 1183) begin n_fail++; $display("FAIL hsync_range: got %0d..%0d want 1048..1183", lo_min, lo_max); end
    n_cmp++; if (lo_cnt != 272) begin n_fail++; $display("FAIL hsync_width: got %0d want 272", lo_cnt); end
    n_cmp++; if (nl_cnt != 2) begin n_fail++; $display("FAIL new_line_count: got %0d want 2", nl_cnt); end
    n_cmp++; if (b_vc !== 11'd2) begin n_fail++; $display("FAIL line_vcount: got %0d want 2", b_vc); end
  endtask

  task automatic test_frame();
    int vb_min, vb_max, vs_min, vs_max, nf_cnt, last_nf, period;
    vb_min = 999; vb_max = -1; vs_min = 999; vs_max = -1; nf_cnt = 0; last_nf = -1; period = -1;
    for (int i = 1; i <= 805; i++) begin
      tick_s(1'b0, 1'b1, 1'b0);
      n_cmp++; if (s_vec !== exp_s) begin n_fail++; $display("FAIL sb_frame: cyc %0d got %h want %h", i, s_vec, exp_s); end
      if (s_vb) begin
        if (int'(s_vc) < vb_min) vb_min = int'(s_vc);
        if (int'(s_vc) > vb_max) vb_max = int'(s_vc);
      end
      if (!s_vs) begin
        if (int'(s_vc) < vs_min) vs_min = int'(s_vc);
        if (int'(s_vc) > vs_max) vs_max = int'(s_vc);
      end
      if (s_nf) begin
        nf_cnt++;
        if (last_nf >= 0) period = i - last_nf;
        last_nf = i;
      end
    end
    n_cmp++; if (vb_min != 10 || vb_max != 15) begin n_fail++; $display("FAIL vblnk_range: got %0d..%0d want 10..15", vb_min, vb_max); end
    n_cmp++; if (vs_min != 11 || vs_max != 12) begin n_fail++; $display("FAIL vsync_range: got %0d..%0d want 11..12", vs_min, vs_max); end
    n_cmp++; if (nf_cnt != 2) begin n_fail++; $display("FAIL new_frame_count: got %0d want 2", nf_cnt); end
    n_cmp++; if (period != 400) begin n_fail++; $display("FAIL frame_period: got %0d want 400", period); end
  endtask

  task automatic test_mode_switch();
    bit found;
    int cnt, hs_hi;
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      tick_s(1'b0, 1'b1, 1'b0);
      n_cmp++; if (s_vec !== exp_s) begin n_fail++; $display("FAIL sb_sw_seek: got %h want %h", s_vec, exp_s); end
      found = (s_vc == 11'd5);
    end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL sw_seek_timeout: got 0 want 1"); end
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      tick_s(1'b0, 1'b1, 1'b1);
      n_cmp++; if (s_vec !== exp_s) begin n_fail++; $display("FAIL sb_sw_wait: got %h want %h", s_vec, exp_s); end
      found = s_nf;
    end
    n_cmp++; if (s_ma !== 1'b1) begin n_fail++; $display("FAIL sw_mode_after_wrap: got %b want 1", s_ma); end
    cnt = 0; hs_hi = 0; found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick_s(1'b0, 1'b1, 1'b1);
      n_cmp++; if (s_vec !== exp_s) begin n_fail++; $display("FAIL sb_sw_mode1: got %h want %h", s_vec, exp_s); end
      cnt++;
      if (s_hs) hs_hi++;
      found = s_nf;
    end
    n_cmp++; if (cnt != 154) begin n_fail++; $display("FAIL mode1_period: got %0d want 154", cnt); end
    n_cmp++; if (hs_hi != 22) begin n_fail++; $display("FAIL mode1_hsync_high: got %0d want 22", hs_hi); end
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick_s(1'b0, 1'b1, 1'b1);
      n_cmp++; if (s_vec !== exp_s) begin n_fail++; $display("FAIL sb_glitch_seek: got %h want %h", s_vec, exp_s); end
      found = (s_vc == 11'd3);
    end
    for (int i = 0; i < 4; i++) begin
      tick_s(1'b0, 1'b1, 1'b0);
      n_cmp++; if (s_vec !== exp_s) begin n_fail++; $display("FAIL sb_glitch: got %h want %h", s_vec, exp_s); end
    end
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick_s(1'b0, 1'b1, 1'b1);
      n_cmp++; if (s_vec !== exp_s) begin n_fail++; $display("FAIL sb_glitch_wait: got %h want %h", s_vec, exp_s); end
      found = s_nf;
    end
    n_cmp++; if (!found || s_ma !== 1'b1) begin n_fail++; $display("FAIL glitch_no_switch: got %b want 1", s_ma); end
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick_s(1'b0, 1'b1, 1'b0);
      n_cmp++; if (s_vec !== exp_s) begin n_fail++; $display("FAIL sb_switch_back: got %h want %h", s_vec, exp_s); end
      found = s_nf;
    end
    n_cmp++; if (!found || s_ma !== 1'b0) begin n_fail++; $display("FAIL switch_back: got %b want 0", s_ma); end
  endtask

  task automatic test_en_half();
    bit found, en_t;
    int cnt, dbl;
    logic prev_nl;
    en_t = 1'b0; dbl = 0; prev_nl = 1'b0; found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      en_t = ~en_t;
      tick_s(1'b0, en_t, 1'b0);
      n_cmp++; if (s_vec !== exp_s) begin n_fail++; $display("FAIL sb_en_half: got %h want %h", s_vec, exp_s); end
      if (prev_nl && s_nl) dbl++;
      prev_nl = s_nl;
      found = s_nf;
    end
    cnt = 0; found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      en_t = ~en_t;
      tick_s(1'b0, en_t, 1'b0);
      n_cmp++; if (s_vec !== exp_s) begin n_fail++; $display("FAIL sb_en_half2: got %h want %h", s_vec, exp_s); end
      if (prev_nl && s_nl) dbl++;
      prev_nl = s_nl;
      cnt++;
      found = s_nf;
    end
    n_cmp++; if (cnt != 800) begin n_fail++; $display("FAIL en_half_period: got %0d want 800", cnt); end
    n_cmp++; if (dbl != 0) begin n_fail++; $display("FAIL pulse_width: got %0d double pulses want 0", dbl); end
  endtask

  task automatic test_reset_mid();
    bit found;
    int nf_cnt, nf_at;
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      tick_s(1'b0, 1'b1, 1'b0);
      n_cmp++; if (s_vec !== exp_s) begin n_fail++; $display("FAIL sb_rmid_seek: got %h want %h", s_vec, exp_s); end
      found = (s_hc == 11'd10) && (s_vc == 11'd7);
    end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL rmid_seek_timeout: got 0 want 1"); end
    tick_s(1'b1, 1'b1, 1'b0);
    n_cmp++; if (s_vec !== exp_s) begin n_fail++; $display("FAIL sb_rmid: got %h want %h", s_vec, exp_s); end
    n_cmp++; if ({s_hc, s_vc, s_nl, s_nf} !== 24'd0) begin n_fail++; $display("FAIL rmid_state: got %h want 0", {s_hc, s_vc, s_nl, s_nf}); end
    nf_cnt = 0; nf_at = -1;
    for (int i = 1; i <= 410; i++) begin
      tick_s(1'b0, 1'b1, 1'b0);
      n_cmp++; if (s_vec !== exp_s) begin n_fail++; $display("FAIL sb_rmid_resume: got %h want %h", s_vec, exp_s); end
      if (s_nf) begin nf_cnt++; nf_at = i; end
    end
    n_cmp++; if (nf_cnt != 1 || nf_at != 400) begin n_fail++; $display("FAIL rmid_resume: got %0d pulses at %0d want 1 at 400", nf_cnt, nf_at); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_fail = 0;
    s_rst = 1'b1; s_en = 1'b0; s_sel = 1'b0;
    b_rst = 1'b1; b_en = 1'b0; b_sel = 1'b0;
    test_reset();
    test_mode0_line();
    test_frame();
    test_mode_switch();
    test_en_half();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
